// File: rtl/reset_sequencer.sv
// Reset sequencer: releases SoC resets once the PLL lock is filtered and stable.
// The peripheral domain (video, UART) is released first, then the CPU core domain
// after a fixed gap. A lock drop re-asserts both resets, and a firmware soft reset
// pulses the core domain only.
//
// Ports:
//   clk_core        core clock (PLL output)
//   reset_n         asynchronous active-low reset (button)
//   pll_locked      PLL lock, asynchronous to clk_core
//   soft_req        firmware soft-reset request, synchronous to clk_core
//   periph_reset_n  peripheral-domain reset, active-low, registered
//   core_reset_n    CPU-domain reset, active-low, registered
//   soft_ack        one-cycle pulse when a soft reset is accepted
//   lock_lost       sticky flag: lock dropped after the peripheral release
//   state           current FSM state, for debug/LEDs
module reset_sequencer #(
    parameter int unsigned LOCK_FILTER = 4,
    parameter int unsigned HOLD_CYCLES = 128,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned SOFT_PULSE  = 32,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk_core,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_req,
    output logic       periph_reset_n,
    output logic       core_reset_n,
    output logic       soft_ack,
    output logic       lock_lost,
    output logic [2:0] state
);

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_FILTER = 3'd1;
    localparam logic [2:0] ST_HOLD   = 3'd2;
    localparam logic [2:0] ST_PERIPH = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_SOFT   = 3'd5;

    // Terminal counts of the shared counter for each timed state
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_PULSE - 1);

    logic             lock_m;
    logic             lock_s;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             armed_q;
    logic             armed_d;
    logic             periph_q;
    logic             periph_d;
    logic             core_q;
    logic             core_d;
    logic             ack_q;
    logic             ack_d;
    logic             lost_q;
    logic             lost_d;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    // State and registered-output flops
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_WAIT;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            ack_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ack_q    <= ack_d;
            lost_q   <= lost_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        periph_d = periph_q;
        core_d   = core_q;
        ack_d    = 1'b0;
        lost_d   = lost_q;

        // Re-arm whenever the request is seen low, so a held request fires only once
        if (!soft_req) begin
            armed_d = 1'b1;
        end

        if ((state_q != ST_WAIT) && !lock_s) begin
            // Lock loss overrides every other transition
            state_d  = ST_WAIT;
            cnt_d    = '0;
            periph_d = 1'b0;
            core_d   = 1'b0;
            if ((state_q == ST_PERIPH) || (state_q == ST_RUN) || (state_q == ST_SOFT)) begin
                lost_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    periph_d = 1'b0;
                    core_d   = 1'b0;
                    if (lock_s) begin
                        state_d = ST_FILTER;
                        cnt_d   = '0;
                    end
                end
                ST_FILTER: begin
                    if (cnt_q == FILTER_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        periph_d = 1'b1;
                        state_d  = ST_PERIPH;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PERIPH: begin
                    if (cnt_q == GAP_LAST) begin
                        core_d  = 1'b1;
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (soft_req && armed_q) begin
                        core_d  = 1'b0;
                        ack_d   = 1'b1;
                        armed_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_SOFT;
                    end
                end
                ST_SOFT: begin
                    if (cnt_q == SOFT_LAST) begin
                        core_d  = 1'b1;
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // Unused encodings recover to WAIT with both resets held
                    state_d  = ST_WAIT;
                    cnt_d    = '0;
                    periph_d = 1'b0;
                    core_d   = 1'b0;
                end
            endcase
        end
    end

    assign periph_reset_n = periph_q;
    assign core_reset_n   = core_q;
    assign soft_ack       = ack_q;
    assign lock_lost      = lost_q;
    assign state          = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed steps; expected output values are queued
// with the edge number at which they must hold, and checked as the edges occur.
module tb_reset_sequencer;

    logic       clk_core;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_req;
    logic       periph_reset_n;
    logic       core_reset_n;
    logic       soft_ack;
    logic       lock_lost;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         edge_no;
        int         sel;
        logic [2:0] val;
    } exp_t;

    exp_t exp_q[$];

    reset_sequencer dut (
        .clk_core       (clk_core),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .soft_req       (soft_req),
        .periph_reset_n (periph_reset_n),
        .core_reset_n   (core_reset_n),
        .soft_ack       (soft_ack),
        .lock_lost      (lock_lost),
        .state          (state)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    localparam int S_PERIPH = 0;
    localparam int S_CORE   = 1;
    localparam int S_ACK    = 2;
    localparam int S_LOST   = 3;
    localparam int S_STATE  = 4;

    function automatic logic [2:0] sample(int sel);
        case (sel)
            S_PERIPH: sample = {2'b00, periph_reset_n};
            S_CORE:   sample = {2'b00, core_reset_n};
            S_ACK:    sample = {2'b00, soft_ack};
            S_LOST:   sample = {2'b00, lock_lost};
            default:  sample = state;
        endcase
    endfunction

    function automatic string tag_of(int sel);
        case (sel)
            S_PERIPH: tag_of = "periph_reset_n";
            S_CORE:   tag_of = "core_reset_n";
            S_ACK:    tag_of = "soft_ack";
            S_LOST:   tag_of = "lock_lost";
            default:  tag_of = "state";
        endcase
    endfunction

    task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    // Queue an expectation, kept sorted by edge number
    task automatic expect_at(int e, int sel, logic [2:0] v);
        exp_t x;
        int   pos;
        x.edge_no = e;
        x.sel     = sel;
        x.val     = v;
        pos       = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].edge_no > e) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, x);
    endtask

    task automatic expect_span(int e0, int e1, int sel, logic [2:0] v);
        for (int e = e0; e <= e1; e++) begin
            expect_at(e, sel, v);
        end
    endtask

    // Advance one clock edge, sample 1 time unit later, retire due expectations
    task automatic tick();
        @(posedge clk_core);
        #1;
        cyc++;
        while (exp_q.size() != 0 && exp_q[0].edge_no <= cyc) begin
            exp_t x;
            x = exp_q.pop_front();
            chk(tag_of(x.sel), sample(x.sel), x.val);
        end
    endtask

    task automatic run_to(int e);
        while (cyc < e) begin
            tick();
        end
    endtask

    task automatic chk_all_reset(string tag);
        chk({tag, "_periph"}, {2'b00, periph_reset_n}, 3'd0);
        chk({tag, "_core"},   {2'b00, core_reset_n},   3'd0);
        chk({tag, "_ack"},    {2'b00, soft_ack},       3'd0);
        chk({tag, "_lost"},   {2'b00, lock_lost},      3'd0);
        chk({tag, "_state"},  state,                   3'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        soft_req   = 1'b0;

        // Power-up: reset low for 5 edges, lock rises so edge 10 samples it first
        #1;
        chk_all_reset("por");
        run_to(5);
        chk_all_reset("por_edge5");
        reset_n = 1'b1;
        run_to(9);
        pll_locked = 1'b1;
        expect_at(12, S_STATE, 3'd1);
        expect_at(16, S_STATE, 3'd2);
        expect_at(143, S_PERIPH, 3'd0);
        expect_at(144, S_PERIPH, 3'd1);
        expect_at(144, S_STATE, 3'd3);
        expect_at(159, S_CORE, 3'd0);
        expect_at(160, S_CORE, 3'd1);
        expect_at(160, S_STATE, 3'd4);
        expect_at(160, S_LOST, 3'd0);
        run_to(165);

        // Asynchronous reset mid-run clears everything without a clock edge
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        #1;
        chk_all_reset("async_rst");
        run_to(167);
        reset_n = 1'b1;

        // Lock glitch during FILTER: release timed from the second rise (edge 175)
        run_to(170);
        pll_locked = 1'b1;
        expect_at(173, S_STATE, 3'd1);
        expect_at(175, S_STATE, 3'd1);
        expect_at(176, S_STATE, 3'd0);
        expect_at(177, S_STATE, 3'd1);
        expect_at(308, S_PERIPH, 3'd0);
        expect_at(309, S_PERIPH, 3'd1);
        expect_at(324, S_CORE, 3'd0);
        expect_at(325, S_CORE, 3'd1);
        expect_at(325, S_LOST, 3'd0);
        run_to(173);
        pll_locked = 1'b0;
        run_to(174);
        pll_locked = 1'b1;
        run_to(330);

        // Single-cycle soft request: one ack, 32-cycle core pulse, periph untouched
        soft_req = 1'b1;
        expect_at(331, S_ACK, 3'd1);
        expect_at(332, S_ACK, 3'd0);
        expect_at(331, S_CORE, 3'd0);
        expect_at(362, S_CORE, 3'd0);
        expect_at(363, S_CORE, 3'd1);
        expect_at(331, S_STATE, 3'd5);
        expect_at(362, S_STATE, 3'd5);
        expect_at(363, S_STATE, 3'd4);
        expect_span(331, 364, S_PERIPH, 3'd1);
        tick();
        soft_req = 1'b0;
        run_to(370);

        // Held request: exactly one accept; a fresh request after release is accepted
        soft_req = 1'b1;
        expect_at(371, S_ACK, 3'd1);
        expect_span(372, 472, S_ACK, 3'd0);
        expect_at(371, S_CORE, 3'd0);
        expect_at(402, S_CORE, 3'd0);
        expect_span(403, 472, S_CORE, 3'd1);
        expect_at(403, S_STATE, 3'd4);
        expect_at(470, S_STATE, 3'd4);
        run_to(470);
        soft_req = 1'b0;
        run_to(472);
        soft_req = 1'b1;
        expect_at(473, S_ACK, 3'd1);
        expect_at(474, S_ACK, 3'd0);
        expect_at(473, S_CORE, 3'd0);
        expect_at(504, S_CORE, 3'd0);
        expect_at(505, S_CORE, 3'd1);
        expect_at(473, S_STATE, 3'd5);
        tick();
        soft_req = 1'b0;
        run_to(520);

        // Lock loss in RUN coinciding with a soft request: WAIT wins, no ack
        pll_locked = 1'b0;
        expect_at(522, S_STATE, 3'd4);
        expect_at(522, S_CORE, 3'd1);
        expect_at(522, S_PERIPH, 3'd1);
        expect_at(522, S_LOST, 3'd0);
        expect_at(523, S_STATE, 3'd0);
        expect_at(523, S_CORE, 3'd0);
        expect_at(523, S_PERIPH, 3'd0);
        expect_at(523, S_ACK, 3'd0);
        expect_at(524, S_ACK, 3'd0);
        expect_at(523, S_LOST, 3'd1);
        run_to(522);
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        run_to(530);

        // Relock replays the full sequence; lock_lost stays set
        pll_locked = 1'b1;
        expect_at(600, S_LOST, 3'd1);
        expect_at(664, S_PERIPH, 3'd0);
        expect_at(665, S_PERIPH, 3'd1);
        expect_at(680, S_CORE, 3'd0);
        expect_at(681, S_CORE, 3'd1);
        expect_at(681, S_LOST, 3'd1);
        run_to(690);

        // Only reset_n clears lock_lost
        reset_n = 1'b0;
        #1;
        chk_all_reset("rst_clears_lost");
        run_to(692);
        reset_n = 1'b1;
        expect_at(694, S_STATE, 3'd0);
        expect_at(695, S_STATE, 3'd1);
        expect_at(826, S_PERIPH, 3'd0);
        expect_at(827, S_PERIPH, 3'd1);
        expect_at(842, S_CORE, 3'd0);
        expect_at(843, S_CORE, 3'd1);
        run_to(850);

        // Lock loss on the SOFT terminal-count edge: core stays low, lock_lost sets
        soft_req = 1'b1;
        expect_at(851, S_ACK, 3'd1);
        tick();
        soft_req = 1'b0;
        expect_at(882, S_STATE, 3'd5);
        expect_at(882, S_CORE, 3'd0);
        expect_at(882, S_LOST, 3'd0);
        expect_at(883, S_STATE, 3'd0);
        expect_at(883, S_CORE, 3'd0);
        expect_at(883, S_PERIPH, 3'd0);
        expect_at(883, S_ACK, 3'd0);
        expect_at(883, S_LOST, 3'd1);
        expect_at(884, S_CORE, 3'd0);
        run_to(880);
        pll_locked = 1'b0;
        run_to(890);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_drained: observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences reset release for the SoC after the iCE40 PLL locks.
- Filters and synchronizes the PLL lock signal, holds reset for a fixed window, then releases the peripheral domain (video, UART) before the CPU core domain.
- Handles PLL lock loss by re-asserting both resets and recording the event.
- Accepts a firmware soft-reset request that resets the core domain only, leaving peripherals running.

Parameters:
LOCK_FILTER, 4, consecutive synchronized-lock cycles required before hold starts (>=1)
HOLD_CYCLES, 128, cycles both resets stay asserted after lock is accepted (>=1)
STAGE_GAP, 16, cycles between periph_reset_n release and core_reset_n release (>=1)
SOFT_PULSE, 32, cycles core_reset_n is asserted for a soft reset (>=1)
CNT_W, 8, shared counter width; must hold max(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP, SOFT_PULSE)

Ports:
clk_core  input  1  core clock (PLL output)
reset_n  input  1  asynchronous, active-low reset (button)
pll_locked  input  1  PLL lock, asynchronous to clk_core
soft_req  input  1  soft-reset request from core output port, synchronous to clk_core
periph_reset_n  output  1  peripheral-domain reset, active-low, registered
core_reset_n  output  1  CPU-domain reset, active-low, registered
soft_ack  output  1  one-cycle pulse when a soft reset is accepted
lock_lost  output  1  sticky flag: lock dropped after periph release
state  output  3  current FSM state encoding, for debug/LEDs

Behaviour:
- Reset values while reset_n=0: periph_reset_n=0, core_reset_n=0, soft_ack=0, lock_lost=0, state=WAIT. The sync flops, counter and the arm flag (armed=1) also reset.
- Lock synchronizer: 2 flops. lock_s is the second flop. All lock decisions use lock_s only.
- State encodings: WAIT=0, FILTER=1, HOLD=2, PERIPH=3, RUN=4, SOFT=5. Values 6 and 7 go to WAIT.
- WAIT: both resets low. When lock_s=1: go to FILTER, cnt=0.
- FILTER: at each edge with lock_s=1, cnt+1. At the edge where cnt==LOCK_FILTER-1 and lock_s=1: go to HOLD, cnt=0.
- HOLD: at the edge where cnt==HOLD_CYCLES-1: periph_reset_n<=1, go to PERIPH, cnt=0.
- PERIPH: at the edge where cnt==STAGE_GAP-1: core_reset_n<=1, go to RUN, cnt=0.
- Release latency: let k be the first edge sampling pll_locked=1.
  - periph_reset_n rises at edge k+2+LOCK_FILTER+HOLD_CYCLES (k+134 with defaults).
  - core_reset_n rises STAGE_GAP edges later (k+150 with defaults).
- RUN: if soft_req=1 and armed=1:
  - core_reset_n<=0, soft_ack<=1, armed<=0, cnt=0, go to SOFT.
  - periph_reset_n stays 1.
- SOFT: at the edge where cnt==SOFT_PULSE-1: core_reset_n<=1, go to RUN.
- Arm flag: armed<=1 on any edge sampling soft_req=0.
  - A request held high across SOFT does not retrigger.
  - soft_req is ignored outside RUN.
- soft_ack is high for exactly one cycle per accepted request.
- Lock loss, in any state other than WAIT with lock_s=0:
  - Next edge: state=WAIT, periph_reset_n=0, core_reset_n=0, cnt=0.
  - Lock loss takes priority over every other transition, including soft_req and counter terminal counts.
  - lock_lost<=1 if the state was PERIPH, RUN or SOFT. It is cleared only by reset_n.
  - Loss in FILTER or HOLD restarts silently.
- Async reset mid-sequence: immediate return to reset values; no glitch on outputs after reset_n deasserts (outputs remain 0 until the sequence completes).
- No combinational path from any input to any output.

Test Plan:
- Power-up: reset_n low 5 cycles, then high; pll_locked rises at edge 10 -> periph_reset_n rises at edge 144, core_reset_n at edge 160, state=4, lock_lost=0.
- Filter glitch: pll_locked high 3 cycles then low 1, then stays high -> state returns to WAIT; release is timed from the second rise; lock_lost stays 0.
- Soft reset: in RUN, soft_req high 1 cycle -> soft_ack 1-cycle pulse; core_reset_n low exactly 32 cycles; periph_reset_n stays 1 throughout.
- Held request: soft_req held high for 100 cycles -> exactly one soft_ack and one 32-cycle core reset; a second request after soft_req returns to 0 is accepted.
- Lock loss in RUN, then relock: drop pll_locked -> both resets low 3 edges after the drop, lock_lost=1; after relock, full sequence replays and lock_lost stays 1 until reset_n.
- Simultaneous events: lock_s falls on the same edge as soft_req, and separately on SOFT terminal count -> WAIT wins, no soft_ack, core_reset_n stays 0.
